// File: rtl/arith_op_arbiter_if.sv
// Request/response bundle for arith_op_arbiter: two requester channels and one result channel.
interface arith_op_arbiter_if #(
  parameter int WIDTH = 4
);
  logic               iReq0Valid;
  logic               oReq0Ready;
  logic [1:0]         iReq0Op;
  logic [WIDTH-1:0]   iReq0A;
  logic [WIDTH-1:0]   iReq0B;
  logic               iReq1Valid;
  logic               oReq1Ready;
  logic [1:0]         iReq1Op;
  logic [WIDTH-1:0]   iReq1A;
  logic [WIDTH-1:0]   iReq1B;
  logic               oRspValid;
  logic               iRspReady;
  logic               oRspId;
  logic [1:0]         oRspOp;
  logic [2*WIDTH-1:0] oRspData;
  logic               oRspDivZero;
  logic               oBusy;

  modport master (
    output iReq0Valid, iReq0Op, iReq0A, iReq0B,
    output iReq1Valid, iReq1Op, iReq1A, iReq1B,
    output iRspReady,
    input  oReq0Ready, oReq1Ready,
    input  oRspValid, oRspId, oRspOp, oRspData, oRspDivZero, oBusy
  );

  modport slave (
    input  iReq0Valid, iReq0Op, iReq0A, iReq0B,
    input  iReq1Valid, iReq1Op, iReq1A, iReq1B,
    input  iRspReady,
    output oReq0Ready, oReq1Ready,
    output oRspValid, oRspId, oRspOp, oRspData, oRspDivZero, oBusy
  );
endinterface

// File: rtl/arith_op_arbiter.sv
// Round-robin sharing of one add/sub/mul/div unit between two requesters.
// Define ARITH_SEQ_DIV_EN for a WIDTH-cycle restoring divider instead of a combinational one.
module arith_op_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic              iClk,
  input  logic              iRst,
  arith_op_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state_q, state_d;
  logic               last_q, last_d;
  logic               id_q, id_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_id_q, rsp_id_d;
  logic [1:0]         rsp_op_q, rsp_op_d;
  logic [2*WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic               rsp_dz_q, rsp_dz_d;

  logic               grant_valid, grant_id;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  logic [2*WIDTH-1:0] alu_data;
  logic               div_zero;

`ifdef ARITH_SEQ_DIV_EN
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH:0]   shifted;
  logic             qbit;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
`endif

  // last_q resets to 1 so that a tie straight out of reset goes to requester 0.
  always_comb begin
    grant_valid = bus.iReq0Valid | bus.iReq1Valid;
    grant_id    = (bus.iReq0Valid && bus.iReq1Valid) ? ~last_q : bus.iReq1Valid;
  end

  assign bus.oReq0Ready  = (state_q == IDLE) && grant_valid && !grant_id;
  assign bus.oReq1Ready  = (state_q == IDLE) && grant_valid && grant_id;
  assign bus.oRspValid   = rsp_valid_q;
  assign bus.oRspId      = rsp_id_q;
  assign bus.oRspOp      = rsp_op_q;
  assign bus.oRspData    = rsp_data_q;
  assign bus.oRspDivZero = rsp_dz_q;
  assign bus.oBusy       = (state_q != IDLE);

  always_comb begin
    sum      = {1'b0, a_q} + {1'b0, b_q};
    diff     = a_q - b_q;
    prod     = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    div_zero = (op_q == 2'b11) && (b_q == '0);
`ifdef ARITH_SEQ_DIV_EN
    quo      = '1;
    rem      = a_q;
`else
    quo      = div_zero ? '1  : a_q / b_q;
    rem      = div_zero ? a_q : a_q % b_q;
`endif
    case (op_q)
      2'b00:   alu_data = {{(WIDTH-1){1'b0}}, sum};
      2'b01:   alu_data = {{WIDTH{1'b0}}, diff};
      2'b10:   alu_data = prod;
      default: alu_data = {rem, quo};
    endcase
  end

`ifdef ARITH_SEQ_DIV_EN
  // One restoring step: the dividend shifts out of a_q while quotient bits shift in.
  always_comb begin
    shifted  = {prem_q, a_q[WIDTH-1]};
    qbit     = (shifted >= {1'b0, b_q});
    rem_next = qbit ? (shifted[WIDTH-1:0] - b_q) : shifted[WIDTH-1:0];
    quo_next = {a_q[WIDTH-2:0], qbit};
  end
`endif

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_op_d    = rsp_op_q;
    rsp_data_d  = rsp_data_q;
    rsp_dz_d    = rsp_dz_q;
`ifdef ARITH_SEQ_DIV_EN
    cnt_d       = cnt_q;
    prem_d      = prem_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          id_d    = grant_id;
          last_d  = grant_id;
          op_d    = grant_id ? bus.iReq1Op : bus.iReq0Op;
          a_d     = grant_id ? bus.iReq1A  : bus.iReq0A;
          b_d     = grant_id ? bus.iReq1B  : bus.iReq0B;
          state_d = EXEC;
`ifdef ARITH_SEQ_DIV_EN
          cnt_d   = CNT_W'(WIDTH - 1);
          prem_d  = '0;
`endif
        end
      end
      EXEC: begin
        rsp_id_d = id_q;
        rsp_op_d = op_q;
        rsp_dz_d = div_zero;
`ifdef ARITH_SEQ_DIV_EN
        if ((op_q == 2'b11) && !div_zero) begin
          a_d    = quo_next;
          prem_d = rem_next;
          if (cnt_q == '0) begin
            rsp_data_d  = {rem_next, quo_next};
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end else begin
          rsp_data_d  = alu_data;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
`else
        rsp_data_d  = alu_data;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
`endif
      end
      RESP: begin
        if (bus.iRspReady) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      id_q        <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_op_q    <= '0;
      rsp_data_q  <= '0;
      rsp_dz_q    <= 1'b0;
`ifdef ARITH_SEQ_DIV_EN
      cnt_q       <= '0;
      prem_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_op_q    <= rsp_op_d;
      rsp_data_q  <= rsp_data_d;
      rsp_dz_q    <= rsp_dz_d;
`ifdef ARITH_SEQ_DIV_EN
      cnt_q       <= cnt_d;
      prem_q      <= prem_d;
`endif
    end
  end

endmodule

// File: tb/tb_arith_op_arbiter.sv
// Self-checking bench for arith_op_arbiter: vector table plus arbitration, backpressure and reset sequences.
module tb_arith_op_arbiter;

  localparam int WIDTH = 4;
`ifdef ARITH_SEQ_DIV_EN
  localparam bit SEQ_DIV = 1'b1;
`else
  localparam bit SEQ_DIV = 1'b0;
`endif

  logic iClk = 1'b0;
  logic iRst = 1'b0;
  int   cyc  = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 iClk = ~iClk;
  always @(posedge iClk) cyc <= cyc + 1;

  arith_op_arbiter_if #(.WIDTH(WIDTH)) bus ();

  arith_op_arbiter #(.WIDTH(WIDTH)) dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus)
  );

  typedef struct {
    logic       id;
    logic [1:0] op;
    logic [7:0] data;
    logic       dz;
    int         acc;
    int         lat;
  } exp_t;

  typedef struct {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] data;
    logic       dz;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[15];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input bit id, input bit v, input logic [1:0] op,
                           input logic [3:0] a, input logic [3:0] b);
    if (!id) begin
      bus.iReq0Valid = v; bus.iReq0Op = op; bus.iReq0A = a; bus.iReq0B = b;
    end else begin
      bus.iReq1Valid = v; bus.iReq1Op = op; bus.iReq1A = a; bus.iReq1B = b;
    end
  endtask

  function automatic logic ready_of(input bit id);
    return id ? bus.oReq1Ready : bus.oReq0Ready;
  endfunction

  function automatic int exp_latency(input logic [1:0] op, input logic [3:0] b);
    return (SEQ_DIV && op == 2'b11 && b != 4'd0) ? WIDTH + 1 : 2;
  endfunction

  // Present one request, wait for its grant, and record the expected response at the accept edge.
  task automatic apply_stimulus(input bit id, input logic [1:0] op, input logic [3:0] a,
                                input logic [3:0] b, input logic [7:0] data, input logic dz);
    int n = 0;
    drive_req(id, 1'b1, op, a, b);
    #1;
    while (!ready_of(id) && n < 20) begin
      @(posedge iClk); #1; n++;
    end
    if (!ready_of(id)) begin
      check_output("grant_timeout", 32'd0, 32'd1);
      drive_req(id, 1'b0, op, a, b);
      return;
    end
    @(posedge iClk); #1;
    sb.push_back('{id, op, data, dz, cyc, exp_latency(op, b)});
    drive_req(id, 1'b0, op, a, b);
  endtask

  // Wait for a response, compare it with the scoreboard, optionally hold it under backpressure, then consume.
  task automatic receive(input int hold);
    int   n = 0;
    exp_t e;
    while (!bus.oRspValid && n < 30) begin
      @(posedge iClk); #1; n++;
    end
    if (!bus.oRspValid) begin
      check_output("rsp_timeout", 32'd0, 32'd1);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (sb.size() == 0) begin
      check_output("unexpected_rsp", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check_output("rsp_id",      bus.oRspId,      e.id);
    check_output("rsp_op",      bus.oRspOp,      e.op);
    check_output("rsp_data",    bus.oRspData,    e.data);
    check_output("rsp_divzero", bus.oRspDivZero, e.dz);
    check_output("rsp_latency", cyc - e.acc + 1, e.lat);
    for (int k = 0; k < hold; k++) begin
      drive_req(1'b0, 1'b1, 2'b00, 4'd1, 4'd1);
      drive_req(1'b1, 1'b1, 2'b00, 4'd2, 4'd2);
      @(posedge iClk); #1;
      check_output("hold_valid",  bus.oRspValid,  1);
      check_output("hold_data",   bus.oRspData,   e.data);
      check_output("hold_id",     bus.oRspId,     e.id);
      check_output("hold_op",     bus.oRspOp,     e.op);
      check_output("hold_dz",     bus.oRspDivZero, e.dz);
      check_output("hold_ready0", bus.oReq0Ready, 0);
      check_output("hold_ready1", bus.oReq1Ready, 0);
    end
    if (hold > 0) begin
      drive_req(1'b0, 1'b0, 2'b00, 4'd0, 4'd0);
      drive_req(1'b1, 1'b0, 2'b00, 4'd0, 4'd0);
      bus.iRspReady = 1'b1;
    end
    @(posedge iClk); #1;
    check_output("rsp_release", bus.oRspValid, 0);
    check_output("idle_busy",   bus.oBusy,     0);
  endtask

  initial begin
    bit seen;
    vecs[0]  = '{2'b00, 4'd15, 4'd15, 8'h1E, 1'b0};
    vecs[1]  = '{2'b00, 4'd0,  4'd0,  8'h00, 1'b0};
    vecs[2]  = '{2'b00, 4'd9,  4'd7,  8'h10, 1'b0};
    vecs[3]  = '{2'b01, 4'd8,  4'd8,  8'h00, 1'b0};
    vecs[4]  = '{2'b01, 4'd0,  4'd1,  8'h0F, 1'b0};
    vecs[5]  = '{2'b01, 4'd3,  4'd5,  8'h0E, 1'b0};
    vecs[6]  = '{2'b10, 4'd0,  4'd9,  8'h00, 1'b0};
    vecs[7]  = '{2'b10, 4'd7,  4'd3,  8'h15, 1'b0};
    vecs[8]  = '{2'b11, 4'd13, 4'd4,  8'h13, 1'b0};
    vecs[9]  = '{2'b11, 4'd7,  4'd0,  8'h7F, 1'b1};
    vecs[10] = '{2'b11, 4'd0,  4'd0,  8'h0F, 1'b1};
    vecs[11] = '{2'b11, 4'd15, 4'd1,  8'h0F, 1'b0};
    vecs[12] = '{2'b11, 4'd3,  4'd7,  8'h30, 1'b0};
    vecs[13] = '{2'b11, 4'd14, 4'd3,  8'h24, 1'b0};
    vecs[14] = '{2'b11, 4'd15, 4'd15, 8'h01, 1'b0};

    drive_req(1'b0, 1'b0, 2'b00, 4'd0, 4'd0);
    drive_req(1'b1, 1'b0, 2'b00, 4'd0, 4'd0);
    bus.iRspReady = 1'b0;
    iRst = 1'b1;
    repeat (3) @(posedge iClk);
    #1;
    check_output("reset_rsp_valid", bus.oRspValid,   0);
    check_output("reset_rsp_data",  bus.oRspData,    0);
    check_output("reset_rsp_id",    bus.oRspId,      0);
    check_output("reset_rsp_op",    bus.oRspOp,      0);
    check_output("reset_rsp_dz",    bus.oRspDivZero, 0);
    check_output("reset_busy",      bus.oBusy,       0);
    check_output("reset_ready0",    bus.oReq0Ready,  0);
    check_output("reset_ready1",    bus.oReq1Ready,  0);
    iRst = 1'b0;
    @(posedge iClk); #1;
    check_output("post_reset_busy", bus.oBusy, 0);

    $display("[TB] arbitration sequence");
    drive_req(1'b0, 1'b1, 2'b00, 4'd9, 4'd8);
    drive_req(1'b1, 1'b1, 2'b01, 4'd3, 4'd5);
    bus.iRspReady = 1'b1;
    #1;
    check_output("tie_ready0", bus.oReq0Ready, 1);
    check_output("tie_ready1", bus.oReq1Ready, 0);
    @(posedge iClk); #1;
    sb.push_back('{1'b0, 2'b00, 8'h11, 1'b0, cyc, 2});
    drive_req(1'b0, 1'b1, 2'b10, 4'd15, 4'd15);
    check_output("exec_ready0", bus.oReq0Ready, 0);
    check_output("exec_ready1", bus.oReq1Ready, 0);
    check_output("exec_busy",   bus.oBusy,      1);
    receive(0);
    check_output("rr_ready1", bus.oReq1Ready, 1);
    check_output("rr_ready0", bus.oReq0Ready, 0);
    @(posedge iClk); #1;
    sb.push_back('{1'b1, 2'b01, 8'h0E, 1'b0, cyc, 2});
    drive_req(1'b1, 1'b0, 2'b00, 4'd0, 4'd0);
    receive(0);
    apply_stimulus(1'b0, 2'b10, 4'd15, 4'd15, 8'hE1, 1'b0);
    receive(0);

    $display("[TB] vector table");
    for (int i = 0; i < 15; i++) begin
      apply_stimulus(1'(i % 2), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].data, vecs[i].dz);
      receive(0);
    end

    $display("[TB] backpressure sequence");
    bus.iRspReady = 1'b0;
    apply_stimulus(1'b0, 2'b11, 4'd13, 4'd4, 8'h13, 1'b0);
    receive(4);

    $display("[TB] reset during execute");
    drive_req(1'b0, 1'b1, 2'b11, 4'd14, 4'd3);
    #1;
    check_output("rst_op_ready0", bus.oReq0Ready, 1);
    @(posedge iClk); #1;
    drive_req(1'b0, 1'b0, 2'b00, 4'd0, 4'd0);
    check_output("rst_op_busy", bus.oBusy, 1);
    #2 iRst = 1'b1;
    #1;
    check_output("midrst_busy",  bus.oBusy,     0);
    check_output("midrst_valid", bus.oRspValid, 0);
    check_output("midrst_data",  bus.oRspData,  0);
    #2 iRst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(posedge iClk); #1;
      if (bus.oRspValid) seen = 1'b1;
    end
    check_output("dropped_op_no_rsp", seen, 0);

    drive_req(1'b0, 1'b1, 2'b00, 4'd1, 4'd2);
    drive_req(1'b1, 1'b1, 2'b00, 4'd4, 4'd4);
    #1;
    check_output("rr_after_reset_ready0", bus.oReq0Ready, 1);
    check_output("rr_after_reset_ready1", bus.oReq1Ready, 0);
    @(posedge iClk); #1;
    sb.push_back('{1'b0, 2'b00, 8'h03, 1'b0, cyc, 2});
    drive_req(1'b0, 1'b0, 2'b00, 4'd0, 4'd0);
    drive_req(1'b1, 1'b0, 2'b00, 4'd0, 4'd0);
    receive(0);

    check_output("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
